// File: rtl/adder_sub_serial_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
// Imported by the top level.
package adder_sub_serial_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_sub_serial_fs.sv
// One-bit full subtractor stage: d = a - b - bin, with the borrow-out in bout.
// Purely combinational.
module adder_sub_serial_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/adder_sub_serial.sv
// Bit-serial 8-bit subtractor: the operands shift LSB first through one full-subtractor
// stage over eight RUN cycles, and the result is published on DONE entry.
module adder_sub_serial
  import adder_sub_serial_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_B,
  output logic             oZero,
  output logic             oOverflow
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   a_sh_reg, b_sh_reg, r_sh_reg;
  logic               borrow_reg;

  logic               fs_d, fs_bout;
  logic               accept, last_bit;
  logic [WIDTH-1:0]   result;

  adder_sub_serial_fs u_fs (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (borrow_reg),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign accept   = iStart && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
  assign result   = {fs_d, r_sh_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (iStart) state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = iStart ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      r_sh_reg   <= '0;
      borrow_reg <= 1'b0;
      oData      <= '0;
      oData_B    <= 1'b0;
      oZero      <= 1'b1;
      oOverflow  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_sh_reg   <= iData_a;
        b_sh_reg   <= iData_b;
        borrow_reg <= iB;
        cnt_reg    <= '0;
      end else if (state_reg == ST_RUN) begin
        a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
        b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
        r_sh_reg   <= result;
        borrow_reg <= fs_bout;
        cnt_reg    <= cnt_reg + 1'b1;
        // On the last bit the shift LSBs hold the original operand sign bits.
        if (last_bit) begin
          oData     <= result;
          oData_B   <= fs_bout;
          oZero     <= (result == '0);
          oOverflow <= (a_sh_reg[0] != b_sh_reg[0]) && (fs_d != a_sh_reg[0]);
        end
      end
    end
  end

  assign oBusy = (state_reg == ST_RUN);
  assign oDone = (state_reg == ST_DONE);

endmodule

// File: tb/tb_adder_sub_serial.sv
// Self-checking bench for adder_sub_serial: directed and random subtractions
// compared against an arithmetic reference model.
module tb_adder_sub_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] da, db;
  logic       bin;
  logic       busy, done;
  logic [7:0] data;
  logic       data_b, zero, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_data;
  logic       exp_b, exp_zero, exp_ovf;

  always #5 clk = ~clk;

  adder_sub_serial dut (
    .iClk      (clk),
    .iRst      (rst),
    .iStart    (start),
    .iData_a   (da),
    .iData_b   (db),
    .iB        (bin),
    .oBusy     (busy),
    .oDone     (done),
    .oData     (data),
    .oData_B   (data_b),
    .oZero     (zero),
    .oOverflow (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, ".data"}, 32'(data), 32'(exp_data));
    check({tag, ".borrow"}, 32'(data_b), 32'(exp_b));
    check({tag, ".zero"}, 32'(zero), 32'(exp_zero));
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic set_reset_expect();
    exp_data = 8'h00; exp_b = 1'b0; exp_zero = 1'b1; exp_ovf = 1'b0;
  endtask

  // Caller is #1 after a rising edge with the DUT in IDLE or DONE; returns #1 after the DONE edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit hold);
    int u, s;
    logic [7:0] nd;
    u  = int'(a) - int'(b) - int'(bi);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    nd = u[7:0];
    da = a; db = b; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) begin
      da    = 8'($urandom);
      db    = 8'($urandom);
      bin   = 1'($urandom);
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (i < 8) begin
        check($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
        check($sformatf("done[%0d]", i), 32'(done), 32'd0);
        if (i == 4) check_results("hold");
      end
    end
    exp_data = nd; exp_b = (u < 0); exp_zero = (nd == 8'h00); exp_ovf = (s < -128) || (s > 127);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_off", 32'(busy), 32'd0);
    check_results($sformatf("op a=%02h b=%02h bi=%0d", a, b, bi));
    $display("op a=%02h b=%02h bi=%0d -> data=%02h B=%0d Z=%0d V=%0d", a, b, bi, data, data_b, zero, ovf);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      @(posedge clk); #1;
      check("idle.done", 32'(done), 32'd0);
      check("idle.busy", 32'(busy), 32'd0);
      check("idle.data", 32'(data), 32'(exp_data));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; da = '0; db = '0; bin = 1'b0;
    set_reset_expect();
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_results("rst");
    rst = 1'b0;
    idle(2);

    run_op(8'h50, 8'h20, 1'b0, 1'b0); idle(1);
    run_op(8'h00, 8'h01, 1'b0, 1'b0); idle(1);
    run_op(8'h80, 8'h01, 1'b0, 1'b0); idle(1);
    run_op(8'h05, 8'h04, 1'b1, 1'b0); idle(1);
    run_op(8'h05, 8'h05, 1'b1, 1'b0);

    // back-to-back with start held high
    run_op(8'hA5, 8'h5A, 1'b0, 1'b1);
    run_op(8'h5A, 8'hA5, 1'b1, 1'b1);
    run_op(8'h7F, 8'h80, 1'b1, 1'b1);
    idle(2);

    // reset while four bits into RUN
    da = 8'h33; db = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    set_reset_expect();
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check_results("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);
    run_op(8'h10, 8'h01, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
